// File: rtl/clk_enable_gen_pkg.sv
// Shared encodings for the clock-enable generator: debug modes and sequencer states.
package clk_enable_gen_pkg;

  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_RUN  = 3'd4
  } state_e;

  // Steady state the sequencer settles into for a given mode (3 behaves as HALT).
  function automatic state_e follow_mode(input logic [1:0] mode);
    state_e nxt;
    case (mode)
      MODE_RUN:  nxt = ST_RUN;
      MODE_STEP: nxt = ST_STEP_WAIT;
      default:   nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clk_enable_gen_cke_div_ch.sv
// One enable channel: counts advanced cycles and pulses cke when the count reaches its ratio.
module cke_div_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             clr,
  input  logic [DIV_W-1:0] ratio,
  output logic             cke,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] last_s;

  // A ratio of zero behaves as one, so the terminal count is zero in both cases.
  assign last_s = (ratio == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (ratio - DIV_W'(1));
  assign wrap   = adv && !clr && (cnt_r == last_s);

  // Divider counter and registered enable pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
      cke   <= 1'b0;
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
      cke   <= 1'b0;
    end else if (wrap) begin
      cnt_r <= {DIV_W{1'b0}};
      cke   <= 1'b1;
    end else if (adv) begin
      cnt_r <= cnt_r + DIV_W'(1);
      cke   <= 1'b0;
    end else begin
      cke   <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with post-reset hold and HALT/RUN/STEP debug control.
module clk_enable_gen #(
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    load,
  input  logic                    step_req,
  output logic                    sync_rst_n,
  output logic [NUM_CH-1:0]       cke,
  output logic                    busy,
  output logic                    step_done,
  output logic [31:0]             tick_cnt
);
  import clk_enable_gen_pkg::*;

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  state_e                  state_r;
  logic [HOLD_W-1:0]       hold_cnt_r;
  logic [NUM_CH*DIV_W-1:0] shadow_r;
  logic                    adv_s;
  logic [NUM_CH-1:0]       wrap_s;
  logic                    unused_wrap_s;

  assign adv_s         = (state_r == ST_RUN) || (state_r == ST_STEP_RUN);
  assign unused_wrap_s = ^wrap_s;

  // Shadow ratios: every channel starts at divide-by-one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i*DIV_W +: DIV_W] <= DIV_W'(1);
      end
    end else if (load) begin
      shadow_r <= div_ratio;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cke_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv_s),
      .clr   (load),
      .ratio (shadow_r[g*DIV_W +: DIV_W]),
      .cke   (cke[g]),
      .wrap  (wrap_s[g])
    );
  end

  // Hold sequencer, mode FSM and tick counter; a finished step jumps straight to the
  // requested mode so a RUN request during a step resumes with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HOLD;
      hold_cnt_r <= {HOLD_W{1'b0}};
      sync_rst_n <= 1'b0;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      tick_cnt   <= 32'd0;
    end else begin
      step_done <= 1'b0;
      if (adv_s) begin
        tick_cnt <= tick_cnt + 32'd1;
      end
      case (state_r)
        ST_HOLD: begin
          hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          if (hold_cnt_r == HOLD_W'(RST_CYCLES - 1)) begin
            sync_rst_n <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        ST_IDLE, ST_RUN: begin
          state_r <= follow_mode(mode);
        end
        ST_STEP_WAIT: begin
          if (mode != MODE_STEP) begin
            state_r <= follow_mode(mode);
          end else if (step_req && !load) begin
            state_r <= ST_STEP_RUN;
            busy    <= 1'b1;
          end
        end
        ST_STEP_RUN: begin
          if (wrap_s[0]) begin
            step_done <= 1'b1;
            busy      <= 1'b0;
            state_r   <= follow_mode(mode);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomized and directed self-checking bench for clk_enable_gen against a behavioural model.
module tb_clk_enable_gen;
  localparam int NUM_CH     = 2;
  localparam int DIV_W      = 8;
  localparam int RST_CYCLES = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [1:0]              mode = 2'd1;
  logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
  logic                    load = 1'b0;
  logic                    step_req = 1'b0;
  logic                    sync_rst_n;
  logic [NUM_CH-1:0]       cke;
  logic                    busy;
  logic                    step_done;
  logic [31:0]             tick_cnt;

  int checks = 0;
  int failures = 0;

  clk_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .div_ratio(div_ratio), .load(load),
    .step_req(step_req), .sync_rst_n(sync_rst_n), .cke(cke), .busy(busy),
    .step_done(step_done), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phases, advanced-cycle counts since last alignment, divide ratios.
  localparam int P_HOLD = 0, P_IDLE = 1, P_RUN = 2, P_WAIT = 3, P_STEP = 4;
  int          ph = P_HOLD;
  int          hold_edges = 0;
  int          acnt [NUM_CH];
  int          dv [NUM_CH];
  logic        m_sr = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [NUM_CH-1:0] m_cke = '0;
  logic [31:0] m_ticks = 32'd0;

  function automatic int eff(input logic [DIV_W-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  function automatic int follow(input logic [1:0] m);
    return (m == 2'd1) ? P_RUN : (m == 2'd2) ? P_WAIT : P_IDLE;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = P_HOLD; hold_edges = 0; m_sr = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_cke = '0; m_ticks = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin acnt[i] = 0; dv[i] = 1; end
    end else begin
      logic adv;
      logic [NUM_CH-1:0] pulse;
      adv = (ph == P_RUN) || (ph == P_STEP);
      pulse = '0;
      if (adv) m_ticks = m_ticks + 32'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (load) begin
          acnt[i] = 0;
          dv[i] = eff(div_ratio[i*DIV_W +: DIV_W]);
        end else if (adv) begin
          acnt[i] = acnt[i] + 1;
          pulse[i] = (acnt[i] % dv[i]) == 0;
        end
      end
      m_done = 1'b0;
      case (ph)
        P_HOLD: begin
          hold_edges++;
          if (hold_edges == RST_CYCLES) begin m_sr = 1'b1; ph = P_IDLE; end
        end
        P_WAIT: begin
          if (mode == 2'd2 && step_req && !load) begin ph = P_STEP; m_busy = 1'b1; end
          else ph = follow(mode);
        end
        P_STEP: begin
          if (pulse[0]) begin m_done = 1'b1; m_busy = 1'b0; ph = follow(mode); end
        end
        default: ph = follow(mode);
      endcase
      m_cke = pulse;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("mdl_sync_rst_n", 32'(sync_rst_n), 32'(m_sr));
    chk("mdl_cke", 32'(cke), 32'(m_cke));
    chk("mdl_busy", 32'(busy), 32'(m_busy));
    chk("mdl_step_done", 32'(step_done), 32'(m_done));
    chk("mdl_tick_cnt", tick_cnt, m_ticks);
  end

  task automatic count_hold(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      edges++;
      if (!sync_rst_n) begin
        chk("hold_cke", 32'(cke), 32'd0);
        chk("hold_tick", tick_cnt, 32'd0);
      end
    end while (!sync_rst_n && edges < 20);
  endtask

  initial begin
    int edges, first, second, c0;
    logic [31:0] t0;

    // Test 1: reset values and post-reset hold.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sync", 32'(sync_rst_n), 32'd0);
    chk("rst_cke", 32'(cke), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_tick", tick_cnt, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; mode = 2'd1; div_ratio = {8'd3, 8'd1}; load = 1'b1;
    count_hold(edges);
    chk("hold_edges", edges, 32'd4);
    @(negedge clk);
    chk("run_entry_tick", tick_cnt, 32'd0);

    // Test 2: ch0 = 1, ch1 = 3 in RUN.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("run_cke0", 32'(cke[0]), 32'd1);
      chk("run_cke1", 32'(cke[1]), 32'((k % 3) == 0));
      chk("run_tick", tick_cnt, 32'(k));
    end

    // Test 3: ch0 = 0 (acts as 1), ch1 = 255.
    div_ratio = {8'd255, 8'd0}; load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("load_cke", 32'(cke), 32'd0);
    first = -1; second = -1; c0 = 0;
    for (int c = 1; c <= 520; c++) begin
      @(negedge clk);
      if (cke[1]) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (cke[0]) c0++;
    end
    chk("div255_first", 32'(first), 32'd255);
    chk("div255_gap", 32'(second - first), 32'd255);
    chk("div0_every", 32'(c0), 32'd520);

    // Test 4: single step with ch0 = 4; a second request while busy is ignored.
    mode = 2'd2; div_ratio = {8'd255, 8'd4}; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    t0 = tick_cnt;
    chk("wait_busy", 32'(busy), 32'd0);
    step_req = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      step_req = (k == 1);
      chk("step_busy", 32'(busy), 32'(k < 4));
      chk("step_done", 32'(step_done), 32'(k == 4));
      chk("step_cke0", 32'(cke[0]), 32'(k == 4));
    end
    chk("step_ticks", tick_cnt - t0, 32'd4);
    repeat (3) @(negedge clk);
    chk("after_step_busy", 32'(busy), 32'd0);
    chk("after_step_ticks", tick_cnt - t0, 32'd4);

    // Test 5: mode change to RUN during a step, then load+step_req in STEP_WAIT.
    step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    @(negedge clk); mode = 2'd1;
    edges = 0;
    do begin @(negedge clk); edges++; end while (!step_done && edges < 10);
    chk("defer_done_seen", 32'(step_done), 32'd1);
    t0 = tick_cnt;
    @(negedge clk);
    chk("defer_no_gap1", tick_cnt - t0, 32'd1);
    @(negedge clk);
    chk("defer_no_gap2", tick_cnt - t0, 32'd2);
    mode = 2'd2;
    @(negedge clk);
    div_ratio = {8'd255, 8'd2}; load = 1'b1; step_req = 1'b1;
    @(negedge clk); load = 1'b0; step_req = 1'b0;
    t0 = tick_cnt;
    repeat (3) @(negedge clk);
    chk("load_drops_step_busy", 32'(busy), 32'd0);
    chk("load_drops_step_tick", tick_cnt - t0, 32'd0);
    step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    chk("step2_busy_a", 32'(busy), 32'd1);
    @(negedge clk);
    chk("step2_busy_b", 32'(busy), 32'd1);
    @(negedge clk);
    chk("step2_done", 32'(step_done), 32'd1);
    chk("step2_ticks", tick_cnt - t0, 32'd2);

    // Test 6: asynchronous reset mid-RUN, then the hold repeats.
    mode = 2'd1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sync", 32'(sync_rst_n), 32'd0);
    chk("async_cke", 32'(cke), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tick", tick_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_hold(edges);
    chk("rehold_edges", edges, 32'd4);

    // Randomized phase; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      step_req = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 19) == 0);
      div_ratio = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 5))};
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0; step_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Synthesizable successor to the bench-only free-running clock source.
- Produces NUM_CH clock-enable pulse trains from the single system clock, each with its own programmable divide ratio; pipeline stages and peripherals gate their registers on these enables.
- Adds a post-reset hold sequencer, plus HALT / RUN / single-STEP modes so a pipeline can be frozen and advanced one master tick at a time for debug.

Parameters:
- NUM_CH, 2, number of enable channels; channel 0 is the master (defines a STEP).
- DIV_W, 8, width of each channel's divide ratio.
- RST_CYCLES, 4, clocks sync_rst_n is held low after rst_n deasserts (must be ≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 = HALT, 1 = RUN, 2 = STEP, 3 = treated as HALT.
- div_ratio  in  NUM_CH*DIV_W  per-channel ratio; channel i occupies bits [i*DIV_W +: DIV_W]; value 0 is treated as 1.
- load  in  1  one-cycle pulse; captures div_ratio into shadow registers.
- step_req  in  1  one-cycle pulse; requests one master step.
- sync_rst_n  out  1  registered, synchronously released reset for downstream logic.
- cke  out  NUM_CH  registered enable pulses.
- busy  out  1  high while a step is in progress.
- step_done  out  1  one-cycle pulse marking the end of a step.
- tick_cnt  out  32  count of advanced cycles; wraps modulo 2^32.

Behaviour:
- **Reset values** (rst_n low, asynchronous):
  - sync_rst_n = 0, cke = 0, busy = 0, step_done = 0, tick_cnt = 0.
  - All channel counters = 0; shadow ratios = 1; FSM = HOLD; hold counter = 0.
- **HOLD state:**
  - The hold counter increments each clock.
  - After RST_CYCLES rising edges with rst_n high, sync_rst_n is registered high and the FSM goes to IDLE.
  - cke stays 0 throughout HOLD.
- **Advance:** an internal per-cycle signal `adv` = (state == RUN) or (state == STEP_RUN).
- **Per-channel divider** (D = shadow ratio, 0 read as 1):
  - If adv and cnt == D-1: cnt <= 0 and cke[i] <= 1.
  - Else if adv: cnt <= cnt+1 and cke[i] <= 0.
  - Else: cnt holds and cke[i] <= 0.
  - Consequences: D = 1 gives cke high on every advanced cycle; D = 3 gives a pulse on every 3rd advanced cycle.
- **tick_cnt** increments on every cycle in which adv = 1.
- **FSM (decided each clock from mode):**
  - IDLE → RUN if mode == 1; → STEP_WAIT if mode == 2; otherwise stays in IDLE. HALT is IDLE.
  - RUN → IDLE if mode is 0 or 3; → STEP_WAIT if mode == 2.
  - STEP_WAIT → STEP_RUN on step_req when load = 0; busy <= 1.
  - STEP_WAIT → IDLE / RUN on a mode change.
  - STEP_RUN: advances until channel 0's counter wraps. On that edge: cke[0] <= 1, step_done <= 1, busy <= 0, next state = STEP_WAIT. The step_done pulse is coincident with cke[0].
  - A mode change during STEP_RUN is deferred: the step completes first, then the FSM follows the new mode.
  - step_req outside STEP_WAIT is ignored; it is not queued.
- **Load:**
  - On load, the shadow ratios are updated and all channel counters are cleared to 0 on the same edge.
  - cke is 0 on that edge, so all channels realign; the first pulse of channel i arrives D_i advanced cycles later.
  - load takes priority over step_req in the same cycle; the step is dropped.
  - load during STEP_RUN is applied, and the step completes on channel 0's new ratio.
- **Simultaneous wraps:** channels that wrap on the same edge pulse together; there is no arbitration.
- **rst_n asserted mid-step or mid-run:** all outputs immediately return to their reset values, and the full HOLD sequence repeats.

Decomposition:
- Shared package: mode encodings (MODE_HALT, MODE_RUN, MODE_STEP) and the FSM state enum (HOLD, IDLE, RUN, STEP_WAIT, STEP_RUN).
- One sub-module, `cke_div_ch`: a single-channel divider with inputs adv, clr, and ratio, and outputs cke and wrap. It is instantiated NUM_CH times with a generate loop. The top level holds the FSM, hold sequencer and tick counter.

Test Plan:
1. Release rst_n with RST_CYCLES = 4 and mode = 1 → sync_rst_n rises on the 4th edge; cke = 0 before that; tick_cnt = 0 until RUN is entered.
2. RUN with ratios ch0 = 1, ch1 = 3 loaded → cke[0] high every cycle; cke[1] high on advanced cycles 3, 6, 9; tick_cnt = 9 after 9 advanced cycles.
3. ch0 ratio = 0 → behaves identically to ratio 1; with ch1 = 255, count 255 advanced cycles between cke[1] pulses.
4. STEP mode, ch0 = 4, pulse step_req → busy high for 4 cycles; step_done and cke[0] high together on the 4th; a second step_req during busy is ignored; tick_cnt increases by exactly 4.
5. STEP_RUN in progress, switch mode to 1 → step completes with step_done, then RUN continues without a gap. Same-cycle load + step_req in STEP_WAIT → ratio updated, no step.
6. rst_n asserted mid-RUN → cke, busy, sync_rst_n and tick_cnt drop to 0 asynchronously, before the next edge; after release, the 4-cycle hold repeats.
